// File: rtl/adder_error_meter_pkg.sv
// rtl/adder_error_meter_pkg.sv - shared widths and FSM encoding for adder error metrics
package adder_error_meter_pkg;

    localparam int SUM_W = 9;
    localparam int CNT_W = 17;
    localparam int ACC_W = CNT_W + SUM_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/abs_diff.sv
// rtl/abs_diff.sv - combinational unsigned |a - b|, larger minus smaller
module abs_diff #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] d
);

    always_comb begin
        if (a >= b) begin
            d = a - b;
        end else begin
            d = b - a;
        end
    end

endmodule

// File: rtl/adder_error_meter.sv
// rtl/adder_error_meter.sv - collects mismatch count, max and sum of error distance
module adder_error_meter
    import adder_error_meter_pkg::*;
#(
    parameter int SUM_W = adder_error_meter_pkg::SUM_W,
    parameter int CNT_W = adder_error_meter_pkg::CNT_W,
    parameter int ACC_W = adder_error_meter_pkg::ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] n_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUM_W-1:0] s_exact,
    input  logic [SUM_W-1:0] s_approx,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_count,
    output logic [SUM_W-1:0] max_ed,
    output logic [ACC_W-1:0] sum_ed,
    output logic [CNT_W-1:0] sample_count
);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] cnt_next;
    logic [SUM_W-1:0] ed;
    logic             accept;
    logic             start_ok;

    logic             s1_valid;
    logic             s1_mis;
    logic [SUM_W-1:0] s1_ed;

    abs_diff #(.W(SUM_W)) u_abs_diff (
        .a (s_exact),
        .b (s_approx),
        .d (ed)
    );

    assign cnt_next = sample_count + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        start_ok = 1'b0;
        accept   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                done     = (state_q == ST_DONE);
                start_ok = start;
                if (start) begin
                    // A zero-length run completes immediately with cleared metrics.
                    state_d = (n_samples == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                accept   = in_valid;
                if (in_valid && (cnt_next == target)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy    = 1'b1;
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target       <= '0;
            sample_count <= '0;
            s1_valid     <= 1'b0;
            s1_mis       <= 1'b0;
            s1_ed        <= '0;
            err_count    <= '0;
            max_ed       <= '0;
            sum_ed       <= '0;
        end else if (start_ok) begin
            target       <= n_samples;
            sample_count <= '0;
            s1_valid     <= 1'b0;
            err_count    <= '0;
            max_ed       <= '0;
            sum_ed       <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_ed        <= ed;
                s1_mis       <= (ed != '0);
                sample_count <= cnt_next;
            end
            // Stage 2 retires the registered distance; DRAIN covers the last one.
            if (s1_valid) begin
                err_count <= err_count + CNT_W'(s1_mis);
                sum_ed    <= sum_ed + ACC_W'(s1_ed);
                if (s1_ed > max_ed) begin
                    max_ed <= s1_ed;
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_error_meter.sv
// tb/tb_adder_error_meter.sv - directed self-checking bench for adder_error_meter
module tb_adder_error_meter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [16:0] n_samples;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  s_exact;
    logic [8:0]  s_approx;
    logic        busy;
    logic        done;
    logic [16:0] err_count;
    logic [8:0]  max_ed;
    logic [25:0] sum_ed;
    logic [16:0] sample_count;

    int checks = 0;
    int errors = 0;

    adder_error_meter dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .n_samples    (n_samples),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .s_exact      (s_exact),
        .s_approx     (s_approx),
        .busy         (busy),
        .done         (done),
        .err_count    (err_count),
        .max_ed       (max_ed),
        .sum_ed       (sum_ed),
        .sample_count (sample_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_metrics(input string tag, input int ec, input int mx, input int sm, input int sc);
        check({tag, " err_count"}, 32'(err_count), ec);
        check({tag, " max_ed"}, 32'(max_ed), mx);
        check({tag, " sum_ed"}, 32'(sum_ed), sm);
        check({tag, " sample_count"}, 32'(sample_count), sc);
    endtask

    task automatic check_ctrl(input string tag, input logic r, input logic b, input logic d);
        check({tag, " in_ready"}, 32'(in_ready), 32'(r));
        check({tag, " busy"}, 32'(busy), 32'(b));
        check({tag, " done"}, 32'(done), 32'(d));
    endtask

    task automatic do_start(input int n);
        start     = 1'b1;
        n_samples = 17'(n);
        @(negedge clk);
        start     = 1'b0;
        n_samples = 17'd0;
    endtask

    task automatic send(input int a, input int b);
        s_exact  = 9'(a);
        s_approx = 9'(b);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle_junk(input int n);
        for (int i = 0; i < n; i++) begin
            s_exact  = 9'(77 + i);
            s_approx = 9'd0;
            in_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    // Called at the negedge after the last accept: one DRAIN cycle, then DONE.
    task automatic finish_run(input string tag);
        check_ctrl({tag, " drain"}, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check_ctrl({tag, " done"}, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        n_samples = 17'd0;
        in_valid  = 1'b0;
        s_exact   = 9'd0;
        s_approx  = 9'd0;
        repeat (2) @(negedge clk);
        check_ctrl("reset", 1'b0, 1'b0, 1'b0);
        check_metrics("reset", 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);

        do_start(4);
        check_ctrl("clean run", 1'b1, 1'b1, 1'b0);
        send(10, 10);
        send(300, 300);
        send(0, 0);
        send(511, 511);
        finish_run("clean");
        check_metrics("clean", 0, 0, 0, 4);

        do_start(4);
        check_metrics("mixed cleared", 0, 0, 0, 0);
        send(255, 254);
        send(100, 110);
        send(511, 0);
        send(7, 7);
        finish_run("mixed");
        check_metrics("mixed", 3, 511, 522, 4);

        do_start(3);
        send(5, 4);
        idle_junk(2);
        send(8, 12);
        idle_junk(1);
        send(1, 1);
        s_exact  = 9'd200;
        s_approx = 9'd0;
        in_valid = 1'b1;
        finish_run("gaps");
        @(negedge clk);
        in_valid = 1'b0;
        check_metrics("gaps", 2, 4, 5, 3);

        do_start(0);
        check_ctrl("zero", 1'b0, 1'b0, 1'b1);
        check_metrics("zero", 0, 0, 0, 0);
        do_start(1);
        check_ctrl("restart", 1'b1, 1'b1, 1'b0);
        send(9, 3);
        finish_run("restart");
        check_metrics("restart", 1, 6, 6, 1);

        do_start(8);
        send(1, 0);
        send(3, 0);
        send(6, 0);
        check("midrun sample_count", 32'(sample_count), 3);
        #2 rst = 1'b1;
        #1;
        check_ctrl("async rst", 1'b0, 1'b0, 1'b0);
        check_metrics("async rst", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_ctrl("post rst idle", 1'b0, 1'b0, 1'b0);

        do_start(2);
        start     = 1'b1;
        n_samples = 17'd1;
        send(2, 3);
        start     = 1'b0;
        n_samples = 17'd0;
        check_ctrl("start ignored in run", 1'b1, 1'b1, 1'b0);
        send(4, 4);
        finish_run("after rst");
        check_metrics("after rst", 1, 1, 1, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
